// File: rtl/gpio_input_conditioner.sv
// Per-pin input conditioning for the GPIO block: synchronizer, optional debounce filter,
// sticky rise/fall flags and a combined interrupt request.
module gpio_input_conditioner #(
    parameter int NumIO          = 8,
    parameter int SyncStages     = 2,
    parameter int DebounceCycles = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [NumIO-1:0] pins_async,
    input  logic [NumIO-1:0] debounce_en,
    input  logic [NumIO-1:0] rise_ie,
    input  logic [NumIO-1:0] fall_ie,
    input  logic [NumIO-1:0] rise_clear,
    input  logic [NumIO-1:0] fall_clear,
    output logic [NumIO-1:0] pins_clean,
    output logic [NumIO-1:0] rise_pending,
    output logic [NumIO-1:0] fall_pending,
    output logic             irq
);

    localparam int CntW = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(DebounceCycles - 1);

    logic [NumIO-1:0] r_sync [SyncStages];
    logic [NumIO-1:0] r_stable;
    logic [NumIO-1:0] r_stable_d;
    logic [CntW-1:0]  r_cnt [NumIO];
    logic [NumIO-1:0] r_rise;
    logic [NumIO-1:0] r_fall;

    logic [NumIO-1:0] w_sync_out;
    logic [NumIO-1:0] w_rise_evt;
    logic [NumIO-1:0] w_fall_evt;

    assign w_sync_out = r_sync[SyncStages-1];
    assign w_rise_evt = r_stable & ~r_stable_d;
    assign w_fall_evt = ~r_stable & r_stable_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < SyncStages; s++) begin
                r_sync[s] <= '0;
            end
        end else begin
            r_sync[0] <= pins_async;
            for (int s = 1; s < SyncStages; s++) begin
                r_sync[s] <= r_sync[s-1];
            end
        end
    end

    // Any sample equal to the accepted level restarts the count, so glitches never accumulate.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stable <= '0;
            for (int i = 0; i < NumIO; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NumIO; i++) begin
                if (!debounce_en[i]) begin
                    r_stable[i] <= w_sync_out[i];
                    r_cnt[i]    <= '0;
                end else if (w_sync_out[i] == r_stable[i]) begin
                    r_cnt[i]    <= '0;
                end else if (r_cnt[i] == CntMax) begin
                    r_stable[i] <= w_sync_out[i];
                    r_cnt[i]    <= '0;
                end else begin
                    r_cnt[i]    <= r_cnt[i] + CntW'(1);
                end
            end
        end
    end

    // A new event outranks a clear arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stable_d <= '0;
            r_rise     <= '0;
            r_fall     <= '0;
        end else begin
            r_stable_d <= r_stable;
            r_rise     <= w_rise_evt | (r_rise & ~rise_clear);
            r_fall     <= w_fall_evt | (r_fall & ~fall_clear);
        end
    end

    assign pins_clean   = r_stable;
    assign rise_pending = r_rise;
    assign fall_pending = r_fall;
    assign irq          = |((r_rise & rise_ie) | (r_fall & fall_ie));

endmodule
